// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle accumulator CPU controller:
// opcode encodings and controller state enumeration.
package cpu_pkg;

    localparam logic [2:0] OP_LDA = 3'b000;
    localparam logic [2:0] OP_STA = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_JMP = 3'b100;
    localparam logic [2:0] OP_JEZ = 3'b101;
    localparam logic [2:0] OP_LDI = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_MEM    = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    // Instructions that need a data-memory access after decode.
    function automatic logic needs_mem(input logic [2:0] op);
        return (op == OP_LDA) || (op == OP_STA) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on the memory port and flags the cycle in
// which the wait limit is hit without a ready. TIMEOUT = 0 disables it.
module mem_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] LAST = LAST_I[CW-1:0];

    logic [CW-1:0] count;

    // Wait-cycle counter: cleared outside a wait, advanced on each unready cycle.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    // Expiry fires in the unready cycle where the count sits at the limit.
    assign expired = (TIMEOUT != 0) && en && (count == LAST);

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle sequencer for the 8-opcode accumulator CPU. Shares one
// handshaked memory port between instruction fetch and data access,
// drives the datapath strobes, and tracks retired instructions and
// memory-wait timeouts.
module multi_cycle_controller
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic             ac_zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_ld,
    output logic             pc_inc,
    output logic             pc_src,
    output logic             rd_mem,
    output logic             ac_src,
    output logic             ld_ac,
    output logic             ld_imm,
    output logic             alu_add,
    output logic             alu_sub,
    output logic             busy,
    output logic             halted,
    output logic             bus_err,
    output logic [CNT_W-1:0] retired
);

    state_t state;
    state_t state_next;
    logic   waiting;
    logic   timer_clr;
    logic   timer_en;
    logic   expired;
    logic   retire;

    assign waiting   = (state == ST_FETCH) || (state == ST_MEM);
    assign timer_clr = !waiting || mem_ready;
    assign timer_en  = waiting && !mem_ready;
    assign busy      = waiting || (state == ST_DECODE);
    assign halted    = (state == ST_HALT);

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Sticky bus error: set on timeout, cleared when restarting from HALT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus_err <= 1'b0;
        end else if (expired) begin
            bus_err <= 1'b1;
        end else if ((state == ST_HALT) && start) begin
            bus_err <= 1'b0;
        end
    end

    // Retired-instruction counter, wrapping naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retired <= '0;
        end else if (retire) begin
            retired <= retired + 1'b1;
        end
    end

    // Next-state logic plus Moore request outputs and qualified strobes.
    always_comb begin
        state_next = state;
        retire     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_ld      = 1'b0;
        pc_inc     = 1'b0;
        pc_src     = 1'b0;
        rd_mem     = 1'b0;
        ac_src     = 1'b0;
        ld_ac      = 1'b0;
        ld_imm     = 1'b0;
        alu_add    = 1'b0;
        alu_sub    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_ld      = 1'b1;
                    pc_inc     = 1'b1;
                    state_next = ST_DECODE;
                end else if (expired) begin
                    state_next = ST_HALT;
                end
            end
            ST_DECODE: begin
                if (needs_mem(opcode)) begin
                    state_next = ST_MEM;
                end else begin
                    retire     = 1'b1;
                    state_next = ST_FETCH;
                    case (opcode)
                        OP_JMP: pc_src = 1'b1;
                        OP_JEZ: pc_src = ac_zero;
                        OP_LDI: begin
                            ld_imm = 1'b1;
                            ld_ac  = 1'b1;
                        end
                        default: state_next = ST_HALT;
                    endcase
                end
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (opcode == OP_STA);
                rd_mem   = (opcode != OP_STA);
                if (mem_ready) begin
                    retire     = 1'b1;
                    state_next = ST_FETCH;
                    case (opcode)
                        OP_LDA: begin
                            ac_src = 1'b1;
                            ld_ac  = 1'b1;
                        end
                        OP_ADD: begin
                            alu_add = 1'b1;
                            ld_ac   = 1'b1;
                        end
                        OP_SUB: begin
                            alu_sub = 1'b1;
                            ld_ac   = 1'b1;
                        end
                        default: ;
                    endcase
                end else if (expired) begin
                    state_next = ST_HALT;
                end
            end
            ST_HALT: begin
                if (start) state_next = ST_FETCH;
            end
            default: state_next = ST_IDLE;
        endcase

        // Keep the datapath still while reset is asserted mid-access.
        if (!rst_n) begin
            ir_ld   = 1'b0;
            pc_inc  = 1'b0;
            pc_src  = 1'b0;
            ac_src  = 1'b0;
            ld_ac   = 1'b0;
            ld_imm  = 1'b0;
            alu_add = 1'b0;
            alu_sub = 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Self-checking bench for multi_cycle_controller. Expected cycle traces are
// generated per instruction from the sequencing rules and compared cycle by cycle.
module tb_multi_cycle_controller;

    localparam int TOUT = 4;
    localparam int CW   = 8;

    localparam logic [2:0] LDA = 3'd0, STA = 3'd1, ADD = 3'd2, SUB = 3'd3;
    localparam logic [2:0] JMP = 3'd4, JEZ = 3'd5, LDI = 3'd6, HLT = 3'd7;

    localparam int B_REQ = 14, B_WE = 13, B_ASEL = 12, B_IRLD = 11, B_PCINC = 10;
    localparam int B_PCSRC = 9, B_RD = 8, B_ACSRC = 7, B_LDAC = 6, B_LDIMM = 5;
    localparam int B_ADD = 4, B_SUB = 3, B_BUSY = 2, B_HALT = 1, B_ERR = 0;

    logic clk = 1'b0;
    logic rst_n, start, ac_zero, mem_ready;
    logic [2:0] opcode;
    logic mem_req, mem_we, addr_sel, ir_ld, pc_inc, pc_src, rd_mem;
    logic ac_src, ld_ac, ld_imm, alu_add, alu_sub, busy, halted, bus_err;
    logic [CW-1:0] retired;
    logic [14:0] obs;

    int n_run  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic       rdy;
        logic       st;
        logic       az;
        logic [2:0] op;
    } stim_t;

    stim_t         st_q[$];
    logic [14:0]   ex_q[$];
    logic [CW-1:0] er_q[$];
    logic [14:0]   ob_q[$];
    logic [CW-1:0] or_q[$];

    logic [CW-1:0] m_ret;
    logic          m_err;
    logic          m_halt;

    always #5 clk = ~clk;

    multi_cycle_controller #(.TIMEOUT(TOUT), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
        .ac_zero(ac_zero), .mem_ready(mem_ready), .mem_req(mem_req),
        .mem_we(mem_we), .addr_sel(addr_sel), .ir_ld(ir_ld), .pc_inc(pc_inc),
        .pc_src(pc_src), .rd_mem(rd_mem), .ac_src(ac_src), .ld_ac(ld_ac),
        .ld_imm(ld_imm), .alu_add(alu_add), .alu_sub(alu_sub), .busy(busy),
        .halted(halted), .bus_err(bus_err), .retired(retired)
    );

    assign obs = {mem_req, mem_we, addr_sel, ir_ld, pc_inc, pc_src, rd_mem,
                  ac_src, ld_ac, ld_imm, alu_add, alu_sub, busy, halted, bus_err};

    function automatic logic [14:0] base(input logic is_busy);
        logic [14:0] e;
        e = '0;
        e[B_BUSY] = is_busy;
        e[B_HALT] = m_halt;
        e[B_ERR]  = m_err;
        return e;
    endfunction

    task automatic push(input logic rdy, input logic st, input logic az,
                        input logic [2:0] op, input logic [14:0] e);
        stim_t s;
        s.rdy = rdy; s.st = st; s.az = az; s.op = op;
        st_q.push_back(s);
        ex_q.push_back(e);
        er_q.push_back(m_ret);
    endtask

    task automatic clear_plan();
        st_q.delete(); ex_q.delete(); er_q.delete();
    endtask

    task automatic model_reset();
        m_ret = '0; m_err = 1'b0; m_halt = 1'b0;
    endtask

    // Idle or halted cycles with start held low.
    task automatic plan_idle(input int n);
        for (int i = 0; i < n; i++)
            push(1'($urandom), 1'b0, 1'($urandom), 3'($urandom), base(1'b0));
    endtask

    // One cycle in IDLE/HALT with start asserted.
    task automatic plan_start();
        push(1'($urandom), 1'b1, 1'($urandom), 3'($urandom), base(1'b0));
        m_err  = 1'b0;
        m_halt = 1'b0;
    endtask

    // Full instruction from FETCH: fw/mw unready cycles before ready.
    task automatic plan_instr(input logic [2:0] op, input int fw, input int mw, input logic az);
        logic [14:0] e;
        for (int k = 0; k <= fw; k++) begin
            e = base(1'b1);
            e[B_REQ] = 1'b1;
            if (k == fw) begin
                e[B_IRLD] = 1'b1; e[B_PCINC] = 1'b1;
            end
            push(k == fw, 1'($urandom), 1'($urandom), 3'($urandom), e);
            if (k != fw && TOUT != 0 && k >= TOUT - 1) begin
                m_err = 1'b1; m_halt = 1'b1;
                return;
            end
        end
        e = base(1'b1);
        if (op == JMP) e[B_PCSRC] = 1'b1;
        if (op == JEZ) e[B_PCSRC] = az;
        if (op == LDI) begin
            e[B_LDIMM] = 1'b1; e[B_LDAC] = 1'b1;
        end
        push(1'($urandom), 1'($urandom), az, op, e);
        if (op >= JMP) begin
            m_ret = m_ret + 1'b1;
            if (op == HLT) m_halt = 1'b1;
            return;
        end
        for (int k = 0; k <= mw; k++) begin
            e = base(1'b1);
            e[B_REQ] = 1'b1; e[B_ASEL] = 1'b1;
            e[B_WE] = (op == STA); e[B_RD] = (op != STA);
            if (k == mw) begin
                if (op == LDA) begin e[B_ACSRC] = 1'b1; e[B_LDAC] = 1'b1; end
                if (op == ADD) begin e[B_ADD] = 1'b1; e[B_LDAC] = 1'b1; end
                if (op == SUB) begin e[B_SUB] = 1'b1; e[B_LDAC] = 1'b1; end
            end
            push(k == mw, 1'($urandom), 1'($urandom), op, e);
            if (k != mw && TOUT != 0 && k >= TOUT - 1) begin
                m_err = 1'b1; m_halt = 1'b1;
                return;
            end
        end
        m_ret = m_ret + 1'b1;
    endtask

    // Apply planned stimulus one cycle at a time and capture DUT outputs.
    task automatic run_plan();
        ob_q.delete(); or_q.delete();
        foreach (st_q[i]) begin
            @(posedge clk); #2;
            mem_ready = st_q[i].rdy;
            start     = st_q[i].st;
            ac_zero   = st_q[i].az;
            opcode    = st_q[i].op;
            #1;
            ob_q.push_back(obs);
            or_q.push_back(retired);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; mem_ready = 1'b0; ac_zero = 1'b0; opcode = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        n_run++;
        if (obs !== 15'd0 || retired !== '0) begin
            n_fail++;
            $display("FAIL reset: outs=%b retired=%0d, expected outs=0 retired=0", obs, retired);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_jmp();
        clear_plan();
        plan_start();
        plan_instr(JMP, 0, 0, 1'b0);
        plan_instr(LDI, 0, 0, 1'b0);
        run_plan();
        for (int i = 0; i < ex_q.size(); i++) begin
            n_run++;
            if (ob_q[i] !== ex_q[i] || or_q[i] !== er_q[i]) begin
                n_fail++;
                $display("FAIL jmp cycle %0d: outs=%b retired=%0d, expected outs=%b retired=%0d",
                         i, ob_q[i], or_q[i], ex_q[i], er_q[i]);
            end
        end
        n_run++;
        if (ob_q[2][B_PCSRC] !== 1'b1 || ob_q[3][B_REQ] !== 1'b1 || or_q[3] !== 8'd1) begin
            n_fail++;
            $display("FAIL jmp_timing: pc_src@2=%b req@3=%b retired@3=%0d, expected 1 1 1",
                     ob_q[2][B_PCSRC], ob_q[3][B_REQ], or_q[3]);
        end
    endtask

    task automatic test_lda_wait();
        int nreq, nac;
        clear_plan();
        plan_instr(LDA, 3, 3, 1'b0);
        run_plan();
        nreq = 0; nac = 0;
        for (int i = 0; i < ex_q.size(); i++) begin
            nreq += int'(ob_q[i][B_REQ]);
            nac  += int'(ob_q[i][B_ACSRC] & ob_q[i][B_LDAC]);
            n_run++;
            if (ob_q[i] !== ex_q[i] || or_q[i] !== er_q[i]) begin
                n_fail++;
                $display("FAIL lda_wait cycle %0d: outs=%b retired=%0d, expected outs=%b retired=%0d",
                         i, ob_q[i], or_q[i], ex_q[i], er_q[i]);
            end
        end
        n_run++;
        if (nreq != 8 || nac != 1) begin
            n_fail++;
            $display("FAIL lda_counts: mem_req cycles=%0d ac pulses=%0d, expected 8 and 1", nreq, nac);
        end
    endtask

    task automatic test_jez();
        clear_plan();
        plan_instr(JEZ, 0, 0, 1'b0);
        plan_instr(JEZ, 1, 0, 1'b1);
        plan_instr(STA, 0, 2, 1'b1);
        plan_instr(SUB, 2, 0, 1'b0);
        plan_instr(ADD, 0, 1, 1'b1);
        run_plan();
        for (int i = 0; i < ex_q.size(); i++) begin
            n_run++;
            if (ob_q[i] !== ex_q[i] || or_q[i] !== er_q[i]) begin
                n_fail++;
                $display("FAIL jez_memops cycle %0d: outs=%b retired=%0d, expected outs=%b retired=%0d",
                         i, ob_q[i], or_q[i], ex_q[i], er_q[i]);
            end
        end
    endtask

    task automatic test_hlt_restart();
        clear_plan();
        plan_instr(HLT, 0, 0, 1'b0);
        plan_idle(5);
        plan_start();
        plan_instr(LDI, 1, 0, 1'b0);
        run_plan();
        for (int i = 0; i < ex_q.size(); i++) begin
            n_run++;
            if (ob_q[i] !== ex_q[i] || or_q[i] !== er_q[i]) begin
                n_fail++;
                $display("FAIL hlt_restart cycle %0d: outs=%b retired=%0d, expected outs=%b retired=%0d",
                         i, ob_q[i], or_q[i], ex_q[i], er_q[i]);
            end
        end
    endtask

    task automatic test_timeout();
        int nadd;
        logic [CW-1:0] ret0;
        clear_plan();
        ret0 = m_ret;
        plan_instr(ADD, 0, 10, 1'b0);
        plan_idle(3);
        plan_start();
        plan_instr(LDI, 0, 0, 1'b0);
        run_plan();
        nadd = 0;
        for (int i = 0; i < ex_q.size(); i++) begin
            nadd += int'(ob_q[i][B_ADD]);
            n_run++;
            if (ob_q[i] !== ex_q[i] || or_q[i] !== er_q[i]) begin
                n_fail++;
                $display("FAIL timeout cycle %0d: outs=%b retired=%0d, expected outs=%b retired=%0d",
                         i, ob_q[i], or_q[i], ex_q[i], er_q[i]);
            end
        end
        // Cycles: fetch 0, decode 1, mem 2..5, halt from 6.
        n_run++;
        if (nadd != 0 || ob_q[6][B_HALT] !== 1'b1 || ob_q[6][B_ERR] !== 1'b1 || or_q[6] !== ret0) begin
            n_fail++;
            $display("FAIL timeout_summary: add pulses=%0d halted=%b bus_err=%b retired=%0d, expected 0 1 1 %0d",
                     nadd, ob_q[6][B_HALT], ob_q[6][B_ERR], or_q[6], ret0);
        end
    endtask

    task automatic test_reset_mid_mem();
        clear_plan();
        plan_instr(LDA, 0, 3, 1'b0);
        void'(st_q.pop_back()); void'(ex_q.pop_back()); void'(er_q.pop_back());
        void'(st_q.pop_back()); void'(ex_q.pop_back()); void'(er_q.pop_back());
        run_plan();
        for (int i = 0; i < ex_q.size(); i++) begin
            n_run++;
            if (ob_q[i] !== ex_q[i] || or_q[i] !== er_q[i]) begin
                n_fail++;
                $display("FAIL rst_mid_mem cycle %0d: outs=%b retired=%0d, expected outs=%b retired=%0d",
                         i, ob_q[i], or_q[i], ex_q[i], er_q[i]);
            end
        end
        @(posedge clk); #2;
        rst_n = 1'b0; mem_ready = 1'b0; start = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        #1;
        n_run++;
        if (obs !== 15'd0 || retired !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_mem_after: outs=%b retired=%0d, expected outs=0 retired=0", obs, retired);
        end
        model_reset();
    endtask

    task automatic test_wrap();
        clear_plan();
        plan_start();
        for (int i = 0; i < 256; i++) plan_instr(LDI, 0, 0, 1'($urandom));
        plan_instr(JMP, 0, 0, 1'b0);
        run_plan();
        for (int i = 0; i < ex_q.size(); i++) begin
            n_run++;
            if (ob_q[i] !== ex_q[i] || or_q[i] !== er_q[i]) begin
                n_fail++;
                $display("FAIL wrap cycle %0d: outs=%b retired=%0d, expected outs=%b retired=%0d",
                         i, ob_q[i], or_q[i], ex_q[i], er_q[i]);
            end
        end
        n_run++;
        if (or_q[512] !== 8'd255 || or_q[513] !== 8'd0) begin
            n_fail++;
            $display("FAIL wrap_value: retired=%0d then %0d, expected 255 then 0", or_q[512], or_q[513]);
        end
    endtask

    task automatic test_random();
        logic [2:0] op;
        int fw, mw;
        clear_plan();
        for (int n = 0; n < 80; n++) begin
            op = 3'($urandom_range(0, 7));
            fw = ($urandom_range(0, 9) == 0) ? 4 : $urandom_range(0, 3);
            mw = ($urandom_range(0, 9) == 0) ? 4 : $urandom_range(0, 3);
            plan_instr(op, fw, mw, 1'($urandom));
            if (m_halt) begin
                plan_idle($urandom_range(0, 3));
                plan_start();
            end
        end
        run_plan();
        for (int i = 0; i < ex_q.size(); i++) begin
            n_run++;
            if (ob_q[i] !== ex_q[i] || or_q[i] !== er_q[i]) begin
                n_fail++;
                $display("FAIL random cycle %0d: outs=%b retired=%0d, expected outs=%b retired=%0d",
                         i, ob_q[i], or_q[i], ex_q[i], er_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_jmp();
        test_lda_wait();
        test_jez();
        test_hlt_restart();
        test_timeout();
        test_reset_mid_mem();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multi_cycle_controller.md
# multi_cycle_controller

Multi-cycle sequencer for the 8-opcode accumulator CPU (LDA, STA, ADD, SUB, JMP, JEZ, LDI, HLT) built around a single shared, handshaked memory port. It steps each instruction through fetch, decode and memory-access states, drives the existing datapath strobes, and shares the one memory port between instruction fetch and data access. It sits between the datapath (PC, IR, AC, ALU) and the memory interface, and also provides a memory-wait timeout and a retired-instruction counter.

## Interface
- TIMEOUT, 16: max cycles to wait for mem_ready in FETCH/MEM; 0 disables the timeout
- CNT_W, 16: width of retired counter
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous reset, active-low
- start  in  1  begin/resume fetching; sampled only in IDLE or HALT
- opcode  in  3  IR[15:13], valid from DECODE onward
- ac_zero  in  1  AC == 0
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access active
- mem_we  out  1  write (STA data phase)
- addr_sel  out  1  0 = PC, 1 = IR[12:0]
- ir_ld, pc_inc  out  1  load IR, increment PC
- pc_src  out  1  load PC from IR address
- rd_mem, ac_src, ld_ac, ld_imm, alu_add, alu_sub  out  1  datapath strobes, same meaning as the single-cycle datapath
- busy  out  1  state not IDLE/HALT
- halted  out  1  state == HALT
- bus_err  out  1  sticky: timeout occurred
- retired  out  CNT_W  completed-instruction count

## Operation
- States: IDLE, FETCH, DECODE, MEM, HALT. Reset -> IDLE; all outputs 0, retired = 0, bus_err = 0.
- IDLE: start -> FETCH.
- FETCH: mem_req = 1, addr_sel = 0. Hold until mem_ready; in that cycle, ir_ld = pc_inc = 1, then -> DECODE.
- DECODE (exactly 1 cycle):
  - JMP: pc_src = 1 -> FETCH.
  - JEZ: pc_src = ac_zero -> FETCH.
  - LDI: ld_imm = ld_ac = 1 -> FETCH.
  - HLT: -> HALT.
  - LDA/STA/ADD/SUB: -> MEM.
- MEM: mem_req = 1, addr_sel = 1, mem_we = (opcode == STA), rd_mem = (opcode != STA). Hold until mem_ready; in that cycle:
  - LDA: ac_src = ld_ac = 1.
  - ADD: alu_add = ld_ac = 1.
  - SUB: alu_sub = ld_ac = 1.
  - STA: no AC strobe.
  - Then -> FETCH.
- HALT: no requests. start -> FETCH; PC is not reset. On that transition, bus_err clears.
- Timeout: a wait counter clears on every entry to FETCH/MEM and increments each cycle without mem_ready. If TIMEOUT != 0 and the counter reaches TIMEOUT-1 without ready: -> HALT and set bus_err. No strobes fire in that cycle.
- retired increments by 1 on each completion, wrapping mod 2^CNT_W:
  - DECODE exit for JMP/JEZ/LDI/HLT;
  - MEM exit on mem_ready.
  - A timed-out instruction does not count.
- start outside IDLE/HALT is ignored. mem_ready outside FETCH/MEM is ignored.

## Timing
- State-only (Moore) outputs: mem_req, mem_we, addr_sel, rd_mem, busy, halted.
- Qualified strobes: ir_ld, pc_inc, and MEM-phase AC strobes are combinational on state & mem_ready. DECODE strobes are combinational on state & opcode/ac_zero. Every strobe lasts exactly 1 cycle.
- Cycle counts with zero-wait memory (mem_ready high on the first request cycle):
  - JMP/JEZ/LDI: 2 cycles.
  - LDA/STA/ADD/SUB: 3 cycles.
  - HLT reaches HALT after 2 cycles.
  - Each wait cycle adds 1.
- mem_req stays high continuously from request until the mem_ready cycle; the address is stable throughout.
- rst_n low mid-access: mem_req drops on the next edge, and no strobe fires in that edge's cycle.
- start and a timeout cannot coincide, since start is ignored in FETCH/MEM.

## Structure
- Shared package cpu_pkg: opcode constants (OP_LDA = 3'b000 … OP_HLT = 3'b111) and the state enum.
- Sub-module mem_wait_timer, parameterized by TIMEOUT:
  - inputs: clr, en;
  - output: expired.

## Test plan
- Reset, start, JMP fetched with zero wait: pc_src high on cycle 2 after start, back in FETCH on cycle 3, retired = 1.
- LDA with mem_ready delayed 3 cycles in both FETCH and MEM: mem_req high for 4+4 cycles, ac_src & ld_ac pulse once, total 9 cycles.
- JEZ with ac_zero = 0 vs 1: pc_src 0 vs 1 in the DECODE cycle.
- HLT then start: halted = 1 and no mem_req while idle; start -> FETCH next cycle, retired continues counting (not cleared).
- TIMEOUT = 4, mem_ready held low in MEM during ADD: HALT after 4 cycles, bus_err = 1, alu_add never pulses, retired unchanged.
- rst_n low during MEM wait: next cycle state IDLE, all outputs 0, retired = 0; 256 + 65280 LDIs (CNT_W = 16) -> retired wraps to 0.
